serial_add_sub: RTL and testbench

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 108 ++++++++++
 tb/tb_serial_add_sub.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice per clock, LSB first.
// Results are latched only on the edge that completes the last slice.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_mode;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_bitA;
    logic             w_bitB;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_accNext;

    // A new operation can start from IDLE or from the DONE cycle (back-to-back).
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

    assign w_bitA = r_a[r_idx];
    assign w_bitB = r_b[r_idx];
    assign w_s    = w_bitA ^ w_bitB ^ r_carry;
    assign w_c    = (w_bitA & w_bitB) | (w_bitA & r_carry) | (w_bitB & r_carry);

    always_comb begin
        w_accNext        = r_acc;
        w_accNext[r_idx] = w_s;
    end

    // Subtraction is a + ~b + ~cin, so B and the carry are pre-inverted at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            r_a     <= a;
            r_b     <= mode ? ~b : b;
            r_acc   <= '0;
            r_carry <= mode ? ~cin : cin;
            r_mode  <= mode;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_acc   <= w_accNext;
                    r_carry <= w_c;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_sum   <= w_accNext;
                        r_cout  <= r_mode ? ~w_c : w_c;
                        r_ovf   <= r_carry ^ w_c;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_IDLE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8 and WIDTH=2: stimulus pushes
// expected {ovf, cout, sum}, a negedge monitor pops and compares on each done.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, mode8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, mode2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;
    int doneCount8 = 0;
    int doneCount2 = 0;

    logic [9:0] q8[$];
    logic [9:0] q2[$];

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic, overflow as signed result out of range.
    function automatic logic [9:0] model(input int w, input logic md, input logic [7:0] av,
                                         input logic [7:0] bv, input logic ci);
        int mask, half, ai, bi, cii, sa, sb, full, r;
        logic co, ov;
        logic [7:0] s;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ai   = int'(av) & mask;
        bi   = int'(bv) & mask;
        cii  = ci ? 1 : 0;
        sa   = (ai >= half) ? ai - (1 << w) : ai;
        sb   = (bi >= half) ? bi - (1 << w) : bi;
        if (!md) begin
            full = ai + bi + cii;
            co   = ((full >> w) & 1) != 0;
            r    = sa + sb + cii;
        end else begin
            full = ai - bi - cii;
            co   = ai < (bi + cii);
            r    = sa - sb - cii;
        end
        s  = 8'(full & mask);
        ov = (r > half - 1) || (r < -half);
        return {ov, co, s};
    endfunction

    task automatic setIn(input int w, input logic st, input logic md, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci);
        if (w == 8) begin
            start8 = st; mode8 = md; a8 = av; b8 = bv; cin8 = ci;
        end else begin
            start2 = st; mode2 = md; a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci;
        end
    endtask

    task automatic setStart(input int w, input logic st);
        if (w == 8) start8 = st;
        else start2 = st;
    endtask

    function automatic logic getDone(input int w);
        return (w == 8) ? done8 : done2;
    endfunction

    function automatic logic getBusy(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction

    function automatic logic [7:0] getSum(input int w);
        return (w == 8) ? sum8 : {6'b0, sum2};
    endfunction

    // Called #1 after an edge with the DUT idle or in DONE; returns #1 after done is seen.
    // runMode: 0 quiet, 1 one start pulse with new operands in RUN, 2 random start/operand noise.
    task automatic applyStimulus(input int w, input logic md, input logic [7:0] av,
                                 input logic [7:0] bv, input logic ci, input logic [9:0] expv,
                                 input int runMode);
        int edges;
        logic [7:0] prevSum;
        prevSum = getSum(w);
        setIn(w, 1'b1, md, av, bv, ci);
        if (w == 8) q8.push_back(expv);
        else q2.push_back(expv);
        @(posedge clk); #1;
        checkOutput("busyAfterStart", 32'(getBusy(w)), 32'd1);
        setIn(w, 1'b0, ~md, ~av, ~bv, ~ci);
        edges = 0;
        do begin
            if (runMode == 1) setStart(w, edges == 3);
            else if (runMode == 2)
                setIn(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            edges++;
            if (edges == 1) checkOutput("sumHeldInRun", 32'(getSum(w)), 32'(prevSum));
        end while (!getDone(w) && edges < 4 * w);
        setStart(w, 1'b0);
        checkOutput("doneLatency", 32'(edges), 32'(w));
    endtask

    always @(negedge clk) begin
        logic [9:0] expv;
        if (done8) begin
            doneCount8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone8: done=1 with no pending operation at %0t", $time);
            end else begin
                expv = q8.pop_front();
                checkOutput("sum8", 32'(sum8), 32'(expv[7:0]));
                checkOutput("cout8", 32'(cout8), 32'(expv[8]));
                checkOutput("ovf8", 32'(ovf8), 32'(expv[9]));
            end
        end
        if (done2) begin
            doneCount2++;
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone2: done=1 with no pending operation at %0t", $time);
            end else begin
                expv = q2.pop_front();
                checkOutput("sum2", 32'(sum2), 32'(expv[1:0]));
                checkOutput("cout2", 32'(cout2), 32'(expv[8]));
                checkOutput("ovf2", 32'(ovf2), 32'(expv[9]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        logic md, ci;
        logic [7:0] av, bv;
        rst = 1'b1;
        setIn(8, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
        setIn(2, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        setIn(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        setIn(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("resetBusy", 32'(busy8), 32'd0);
        checkOutput("resetDone", 32'(done8), 32'd0);
        checkOutput("resetSum", 32'(sum8), 32'd0);
        checkOutput("resetCout", 32'(cout8), 32'd0);
        checkOutput("resetOvf", 32'(ovf8), 32'd0);
        checkOutput("resetBusy2", 32'(busy2), 32'd0);
        rst = 1'b0;

        // Directed vectors, start accepted on the first edge after reset release.
        applyStimulus(8, 1'b0, 8'hC8, 8'h37, 1'b1, {1'b0, 1'b1, 8'h00}, 0);
        applyStimulus(8, 1'b0, 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, 0);
        @(posedge clk); #1;
        checkOutput("busyIdleAfterDone", 32'(busy8), 32'd0);
        applyStimulus(8, 1'b1, 8'h05, 8'h07, 1'b0, {1'b0, 1'b1, 8'hFE}, 0);
        applyStimulus(8, 1'b1, 8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F}, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sumHeldInIdle", 32'(sum8), 32'h7F);

        cnt = doneCount8;
        applyStimulus(8, 1'b0, 8'h3C, 8'h4D, 1'b1, {1'b1, 1'b0, 8'h8A}, 1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("ignoredStartDonePulses", 32'(doneCount8 - cnt), 32'd1);

        // Abort: reset lands on the edge that ends the 4th RUN cycle.
        setIn(8, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        setStart(8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cnt = doneCount8;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abortBusy", 32'(busy8), 32'd0);
        checkOutput("abortDone", 32'(done8), 32'd0);
        checkOutput("abortSum", 32'(sum8), 32'd0);
        checkOutput("abortCout", 32'(cout8), 32'd0);
        checkOutput("abortOvf", 32'(ovf8), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abortNoDone", 32'(doneCount8 - cnt), 32'd0);
        applyStimulus(8, 1'b1, 8'h10, 8'h20, 1'b1, {1'b0, 1'b1, 8'hEF}, 0);

        // Small-width directed vectors.
        applyStimulus(2, 1'b0, 8'h01, 8'h01, 1'b0, {1'b1, 1'b0, 8'h02}, 0);
        applyStimulus(2, 1'b1, 8'h00, 8'h00, 1'b1, {1'b0, 1'b1, 8'h03}, 0);
        applyStimulus(2, 1'b1, 8'h02, 8'h01, 1'b0, {1'b1, 1'b0, 8'h01}, 0);
        repeat (2) @(posedge clk);
        #1;

        // Random sets, roughly half issued back-to-back from the DONE cycle.
        foreach (q8[i]) ;
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 8 : 2;
            for (int n = 0; n < 1000; n++) begin
                md = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                av = 8'($urandom_range(0, 255));
                bv = 8'($urandom_range(0, 255));
                if (w == 2) begin
                    av = av & 8'h03;
                    bv = bv & 8'h03;
                end
                applyStimulus(w, md, av, bv, ci, model(w, md, av, bv, ci), 2);
                if ($urandom_range(0, 1) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            repeat (3) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("q8Drained", 32'(q8.size()), 32'd0);
        checkOutput("q2Drained", 32'(q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
